// File: rtl/fetch_unit_if.sv
// Fetch unit bus bundle: instruction memory port, IF/ID write port
// and the hazard/branch/halt controls seen by the fetch stage.
interface fetch_unit_if;
  logic        iREN;
  logic [31:0] iaddr;
  logic        ihit;
  logic [31:0] iload;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_addr;
  logic        halt;
  logic        ifid_WEN;
  logic [31:0] instruction_out;
  logic [31:0] next_address_out;
  logic        halted;

  modport master (
    output iREN, iaddr, ifid_WEN,
    output instruction_out, next_address_out, halted,
    input  ihit, iload, stall,
    input  redirect, redirect_addr, halt
  );

  modport slave (
    input  iREN, iaddr, ifid_WEN,
    input  instruction_out, next_address_out, halted,
    output ihit, iload, stall,
    output redirect, redirect_addr, halt
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, one-entry hold buffer for
// words fetched under stall, redirect and halt handling.
module fetch_unit #(
  parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
  input  logic       CLK,
  input  logic       RST,
  fetch_unit_if.master fu
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t      state, state_nx;
  logic [31:0] pc, pc_nx;
  logic [31:0] buf_instr, buf_instr_nx;
  logic [31:0] buf_next, buf_next_nx;
  logic [31:0] pc_plus4;
  logic [31:0] redir_pc;

  assign pc_plus4 = pc + 32'd4;
  assign redir_pc = {fu.redirect_addr[31:2], 2'b00};
  assign fu.iaddr = pc;

  // State, PC and hold-buffer registers; reset discards everything.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= FETCH;
      pc        <= PC_INIT;
      buf_instr <= 32'h0;
      buf_next  <= 32'h0;
    end else begin
      state     <= state_nx;
      pc        <= pc_nx;
      buf_instr <= buf_instr_nx;
      buf_next  <= buf_next_nx;
    end
  end

  // Next-state and outputs; redirect beats halt beats normal flow.
  always_comb begin
    state_nx            = state;
    pc_nx               = pc;
    buf_instr_nx        = buf_instr;
    buf_next_nx         = buf_next;
    fu.iREN             = 1'b0;
    fu.ifid_WEN         = 1'b0;
    fu.instruction_out  = 32'h0;
    fu.next_address_out = 32'h0;
    fu.halted           = 1'b0;
    if (!RST) begin
      case (state)
        FETCH: begin
          fu.iREN = 1'b1;
          if (fu.redirect) begin
            fu.ifid_WEN = 1'b1;
            pc_nx       = redir_pc;
          end else begin
            if (fu.ihit) begin
              if (!fu.stall) begin
                fu.ifid_WEN         = 1'b1;
                fu.instruction_out  = fu.iload;
                fu.next_address_out = pc_plus4;
                if (!fu.halt)
                  pc_nx = pc_plus4;
              end else if (!fu.halt) begin
                buf_instr_nx = fu.iload;
                buf_next_nx  = pc_plus4;
                pc_nx        = pc_plus4;
                state_nx     = HOLD;
              end
            end else begin
              fu.ifid_WEN = !fu.stall;
            end
            if (fu.halt)
              state_nx = HALT;
          end
        end
        HOLD: begin
          if (fu.redirect) begin
            fu.ifid_WEN = 1'b1;
            pc_nx       = redir_pc;
            state_nx    = FETCH;
          end else if (fu.halt) begin
            fu.ifid_WEN = !fu.stall;
            state_nx    = HALT;
          end else if (!fu.stall) begin
            fu.ifid_WEN         = 1'b1;
            fu.instruction_out  = buf_instr;
            fu.next_address_out = buf_next;
            state_nx            = FETCH;
          end
        end
        HALT: begin
          fu.halted   = 1'b1;
          fu.ifid_WEN = !fu.stall;
        end
        default: state_nx = FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: streaming, stall/hold, redirect,
// halt, reset from any state and PC wraparound.
module tb_fetch_unit;

  logic CLK;
  logic RST;
  int   n_chk;
  int   n_fail;

  fetch_unit_if bus ();

  fetch_unit #(.PC_INIT(32'h0)) dut (
    .CLK (CLK),
    .RST (RST),
    .fu  (bus.master)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return 32'hA500_0000 ^ a;
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag,
                         input logic        ren,
                         input logic [31:0] addr,
                         input logic        wen,
                         input logic [31:0] ins,
                         input logic [31:0] nxt,
                         input logic        hlt);
    chk({tag, ".iREN"}, {31'h0, bus.iREN}, {31'h0, ren});
    chk({tag, ".iaddr"}, bus.iaddr, addr);
    chk({tag, ".WEN"}, {31'h0, bus.ifid_WEN}, {31'h0, wen});
    chk({tag, ".instr"}, bus.instruction_out, ins);
    chk({tag, ".next"}, bus.next_address_out, nxt);
    chk({tag, ".halted"}, {31'h0, bus.halted}, {31'h0, hlt});
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic        hit,
                       input logic [31:0] ld,
                       input logic        stl,
                       input logic        rd,
                       input logic [31:0] ra,
                       input logic        hl);
    bus.ihit          = hit;
    bus.iload         = ld;
    bus.stall         = stl;
    bus.redirect      = rd;
    bus.redirect_addr = ra;
    bus.halt          = hl;
    #1;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    RST    = 1'b1;
    drive(0, 0, 0, 0, 0, 0);

    // reset: outputs forced quiet
    chk("rst.iREN", {31'h0, bus.iREN}, 32'h0);
    chk("rst.WEN", {31'h0, bus.ifid_WEN}, 32'h0);
    chk("rst.instr", bus.instruction_out, 32'h0);
    chk("rst.next", bus.next_address_out, 32'h0);
    chk("rst.halted", {31'h0, bus.halted}, 32'h0);
    tick();
    chk_out("rst2", 0, 32'h0, 0, 0, 0, 0);
    RST = 1'b0;

    // streaming fetch, one word per cycle
    drive(1, word_at(32'h0), 0, 0, 0, 0);
    chk_out("s0", 1, 32'h0, 1, word_at(32'h0), 32'h4, 0);
    tick();
    drive(1, word_at(32'h4), 0, 0, 0, 0);
    chk_out("s4", 1, 32'h4, 1, word_at(32'h4), 32'h8, 0);
    tick();

    // hit under stall at PC=8, then three held cycles
    drive(1, word_at(32'h8), 1, 0, 0, 0);
    chk_out("st8", 1, 32'h8, 0, 0, 0, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(0, 32'hDEAD_BEEF, 1, 0, 0, 0);
      chk_out("hold", 0, 32'hC, 0, 0, 0, 0);
      tick();
    end
    drive(0, 32'hDEAD_BEEF, 0, 0, 0, 0);
    chk_out("rel", 0, 32'hC, 1, word_at(32'h8), 32'hC, 0);
    tick();
    drive(1, word_at(32'hC), 0, 0, 0, 0);
    chk_out("s12", 1, 32'hC, 1, word_at(32'hC), 32'h10, 0);
    tick();
    drive(1, word_at(32'h10), 0, 0, 0, 0);
    chk_out("s16", 1, 32'h10, 1, word_at(32'h10), 32'h14, 0);
    tick();

    // redirect at PC=20 drops the fetched word
    drive(1, word_at(32'h14), 0, 1, 32'h100, 0);
    chk_out("rd20", 1, 32'h14, 1, 0, 0, 0);
    tick();
    drive(1, word_at(32'h100), 0, 0, 0, 0);
    chk_out("s100", 1, 32'h100, 1, word_at(32'h100), 32'h104, 0);
    tick();

    // misses: bubble when not stalled, no write when stalled
    drive(0, 32'hDEAD_BEEF, 0, 0, 0, 0);
    chk_out("miss", 1, 32'h104, 1, 0, 0, 0);
    tick();
    drive(0, 32'hDEAD_BEEF, 1, 0, 0, 0);
    chk_out("miss_st", 1, 32'h104, 0, 0, 0, 0);
    tick();

    // redirect while holding a buffered word (low addr bits masked)
    drive(1, word_at(32'h104), 1, 0, 0, 0);
    chk_out("st104", 1, 32'h104, 0, 0, 0, 0);
    tick();
    drive(0, 32'hDEAD_BEEF, 1, 1, 32'h203, 0);
    chk_out("rdhold", 0, 32'h108, 1, 0, 0, 0);
    tick();
    drive(1, word_at(32'h200), 0, 0, 0, 0);
    chk_out("s200", 1, 32'h200, 1, word_at(32'h200), 32'h204, 0);
    tick();

    // move to PC=40 and halt there
    drive(0, 0, 0, 1, 32'h28, 0);
    tick();
    drive(1, word_at(32'h28), 0, 0, 0, 1);
    chk_out("halt40", 1, 32'h28, 1, word_at(32'h28), 32'h2C, 0);
    tick();
    drive(1, 32'hDEAD_BEEF, 0, 0, 0, 0);
    chk_out("halted", 0, 32'h28, 1, 0, 0, 1);
    tick();
    drive(1, 32'hDEAD_BEEF, 0, 1, 32'h300, 1);
    chk_out("h_rd", 0, 32'h28, 1, 0, 0, 1);
    tick();
    drive(0, 0, 1, 0, 0, 0);
    chk_out("h_st", 0, 32'h28, 0, 0, 0, 1);
    RST = 1'b1;
    #1;
    chk_out("h_rst", 0, 32'h28, 0, 0, 0, 0);
    tick();
    RST = 1'b0;
    drive(1, word_at(32'h0), 0, 0, 0, 0);
    chk_out("post_h", 1, 32'h0, 1, word_at(32'h0), 32'h4, 0);

    // wrap at the top of the address space
    drive(0, 0, 0, 1, 32'hFFFF_FFFF, 0);
    tick();
    drive(1, word_at(32'hFFFF_FFFC), 0, 0, 0, 0);
    chk_out("wrap", 1, 32'hFFFF_FFFC, 1,
            word_at(32'hFFFF_FFFC), 32'h0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    chk("wrap.iaddr", bus.iaddr, 32'h0);

    // reset while holding a buffered word discards it
    drive(1, word_at(32'h0), 1, 0, 0, 0);
    tick();
    RST = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    tick();
    RST = 1'b0;
    drive(0, 32'hDEAD_BEEF, 0, 0, 0, 0);
    chk_out("rst_hold", 1, 32'h0, 1, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: PC_INIT, 32'h00000000, PC value loaded on reset.
REQ-002 CLK  input  1  pipeline clock; all state updates on rising edge.
REQ-003 RST  input  1  synchronous, active-high reset, sampled on rising CLK.
REQ-004 iREN  output  1  instruction-memory read request.
REQ-005 iaddr  output  32  fetch address, always equal to the PC register.
REQ-006 ihit  input  1  iload valid this cycle for the current iaddr.
REQ-007 iload  input  32  instruction word from instruction memory.
REQ-008 stall  input  1  hazard unit: IF/ID latch must hold.
REQ-009 redirect  input  1  taken branch/jump: discard fetch, restart at redirect_addr.
REQ-010 redirect_addr  input  32  new PC when redirect=1; bits [1:0] ignored and forced to 0.
REQ-011 halt  input  1  halt instruction decoded; stop fetching.
REQ-012 ifid_WEN  output  1  write enable to the IF/ID latch.
REQ-013 instruction_out  output  32  instruction to the IF/ID latch; 32'h0 (nop) for a bubble.
REQ-014 next_address_out  output  32  PC+4 of the delivered instruction; 32'h0 for a bubble.
REQ-015 halted  output  1  high while in HALT.

Function
REQ-016 States SHALL be FETCH, HOLD, HALT; PC and a one-entry buffer (buf_instr, buf_next) SHALL be registered; all outputs SHALL be combinational from state, PC, buffer and inputs.
REQ-017 PC arithmetic SHALL be 32-bit unsigned, PC+4 wrapping 32'hFFFFFFFC -> 32'h00000000 without error.
REQ-018 Priority each cycle SHALL be: RST > redirect > halt > normal operation.
REQ-019 FETCH: iREN=1, iaddr=PC.
REQ-020 FETCH, redirect=1: PC<=redirect_addr; ifid_WEN=1 with bubble regardless of stall; ihit data discarded; stay FETCH.
REQ-021 FETCH, ihit=1, stall=0: ifid_WEN=1, instruction_out=iload, next_address_out=PC+4; PC<=PC+4 (zero-bubble latency, one instruction per cycle).
REQ-022 FETCH, ihit=1, stall=1: ifid_WEN=0; buf_instr<=iload, buf_next<=PC+4, PC<=PC+4; go HOLD.
REQ-023 FETCH, ihit=0: PC unchanged; ifid_WEN=!stall with bubble.
REQ-024 HOLD: iREN=0; stall=1 -> ifid_WEN=0, stay; stall=0 -> ifid_WEN=1, instruction_out=buf_instr, next_address_out=buf_next, go FETCH.
REQ-025 HOLD, redirect=1: buffer dropped, PC<=redirect_addr, ifid_WEN=1 bubble, go FETCH.
REQ-026 halt=1 (no redirect) in FETCH or HOLD: go HALT next cycle; current-cycle outputs follow REQ-021..024 except PC SHALL NOT advance and buffer SHALL NOT deliver.
REQ-027 HALT: iREN=0, halted=1, ifid_WEN=!stall with bubble; redirect and halt ignored; exit only by RST.
REQ-028 No instruction SHALL be delivered twice or skipped; each ihit not discarded by redirect SHALL reach IF/ID exactly once, in PC order.

Reset
REQ-029 While RST=1: next state FETCH, PC<=PC_INIT, buffer<=0; outputs iREN=0, ifid_WEN=0, instruction_out=0, next_address_out=0, halted=0.
REQ-030 RST asserted in any state, including HOLD with a buffered instruction or HALT, SHALL discard all state; first fetch at PC_INIT in the cycle after RST deasserts.

Verification
REQ-031 Reset, ihit=1 every cycle, iload=PC-derived, stall=0 -> iaddr 0,4,8,...; WEN=1 each cycle; next_address_out 4,8,12.
REQ-032 ihit=1 at PC=8 with stall=1 for 3 cycles -> HOLD, iREN=0, WEN=0 for 3 cycles; on release instruction from addr 8, next_address_out=12, then fetch at 12.
REQ-033 redirect=1, redirect_addr=32'h100 with ihit=1 at PC=20 -> bubble written (WEN=1, instr=0), next iaddr=32'h100, addr-20 word never delivered.
REQ-034 redirect in HOLD with stall=1 -> buffer dropped, bubble written, next iaddr=redirect_addr.
REQ-035 halt=1 at PC=40 -> halted=1 next cycle, iREN=0 thereafter, PC frozen at 40; RST -> iaddr=PC_INIT, halted=0.
REQ-036 PC=32'hFFFFFFFC, ihit=1, stall=0 -> next_address_out=0, next iaddr=0.
